// File: rtl/ham_secded_dec_pipe_if.sv
// Stream interface for the pipelined Hamming SECDED decoder.
//   master : codeword producer + decoded-word consumer side (drives in_valid,
//            code_in, correct_en, out_ready)
//   slave  : the decoder itself
// Widths are derived from DATA_W exactly as in the decoder:
//   PAR_W  = smallest r with 2^r >= DATA_W+r+1
//   CODE_W = DATA_W+PAR_W+1 (bit 0 is the overall parity bit)
interface ham_secded_dec_pipe_if #(
  parameter int DATA_W = 4
);
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++)
      if ((1 << r) < dw + r + 1) r = r + 1;
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_corr;
  logic              err_uncorr;
  logic [PAR_W:0]    err_pos;

  modport master (
    output in_valid, code_in, correct_en, out_ready,
    input  in_ready, out_valid, data_out, err_corr, err_uncorr, err_pos
  );

  modport slave (
    input  in_valid, code_in, correct_en, out_ready,
    output in_ready, out_valid, data_out, err_corr, err_uncorr, err_pos
  );
endinterface

// File: rtl/ham_secded_dec_pipe.sv
// Pipelined, parameterised Hamming SECDED decoder with valid/ready streaming,
// a correct/detect-only mode and saturating error counters.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready/code_in/correct_en in,
//                 out_valid/out_ready/data_out/err_corr/err_uncorr/err_pos out
//   cnt_clr     : synchronous clear of both counters (beats an increment)
//   corr_cnt    : delivered words with err_corr set (saturating)
//   uncorr_cnt  : delivered words with err_uncorr set (saturating)
//
// Pipeline: stage 1 holds codeword, syndrome, overall parity and correct_en;
// stage 2 holds corrected data and flags. Each stage advances when its
// downstream slot is empty or being drained, so a full pipe still moves one
// word per cycle while out_ready stays high.
module ham_secded_dec_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ham_secded_dec_pipe_if.slave bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++)
      if ((1 << r) < dw + r + 1) r = r + 1;
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;
  localparam int STAGES = 2;

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Hamming position carrying data bit j: j-th non-power-of-two position >= 1.
  function automatic int data_pos(input int j);
    int k;
    int pos;
    k   = 0;
    pos = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if (!is_pow2(p)) begin
        if (k == j) pos = p;
        k = k + 1;
      end
    end
    return pos;
  endfunction

  // vld_pipe[1] = stage-1 valid, vld_pipe[2] = output valid
  logic [STAGES:1] vld_pipe;
  logic            adv2;
  logic            adv1;
  logic            fire_out;

  assign adv2         = ~vld_pipe[2] | bus.out_ready;
  assign adv1         = ~vld_pipe[1] | adv2;
  assign bus.in_ready = adv1;
  assign fire_out     = vld_pipe[2] & bus.out_ready;

  // ---------------- stage 1: syndrome + overall parity ----------------
  logic [PAR_W-1:0] syn_d;
  logic             par_d;

  always_comb begin
    syn_d = '0;
    for (int p = 1; p < CODE_W; p++)
      for (int i = 0; i < PAR_W; i++)
        if (((p >> i) & 1) == 1) syn_d[i] = syn_d[i] ^ bus.code_in[p];
  end

  assign par_d = ^bus.code_in;

  logic [CODE_W-1:0] s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s1_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_code     <= '0;
      s1_syn      <= '0;
      s1_par      <= 1'b0;
      s1_ce       <= 1'b0;
    end else if (adv1) begin
      vld_pipe[1] <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code <= bus.code_in;
        s1_syn  <= syn_d;
        s1_par  <= par_d;
        s1_ce   <= bus.correct_en;
      end
    end
  end

  // ---------------- stage 2: classify, correct, extract ----------------
  logic              syn_nz;
  logic              syn_in_range;
  logic              single;
  logic              par_only;
  logic              dbl;
  logic              out_of_range;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] data_d;
  logic              corr_d;
  logic              uncorr_d;
  logic [PAR_W:0]    pos_d;

  assign syn_nz       = |s1_syn;
  // Syndromes beyond the last real position only exist in shortened codes.
  assign syn_in_range = {1'b0, s1_syn} < (PAR_W+1)'(CODE_W);
  assign single       = s1_par &  syn_nz &  syn_in_range;
  assign par_only     = s1_par & ~syn_nz;
  assign dbl          = ~s1_par & syn_nz;
  assign out_of_range = s1_par &  syn_nz & ~syn_in_range;

  // Only a real in-range single error is ever flipped, and only when enabled.
  assign flip_mask  = (single & s1_ce) ? (CODE_W'(1) << s1_syn) : '0;
  assign fixed_code = s1_code ^ flip_mask;

  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    localparam int DP = data_pos(j);
    assign data_d[j] = fixed_code[DP];
  end

  assign corr_d   = single | par_only;
  assign uncorr_d = dbl | out_of_range;
  assign pos_d    = single ? {1'b0, s1_syn} : '0;

  logic [DATA_W-1:0] data_q;
  logic              corr_q;
  logic              uncorr_q;
  logic [PAR_W:0]    pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      data_q      <= '0;
      corr_q      <= 1'b0;
      uncorr_q    <= 1'b0;
      pos_q       <= '0;
    end else if (adv2) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        data_q   <= data_d;
        corr_q   <= corr_d;
        uncorr_q <= uncorr_d;
        pos_q    <= pos_d;
      end
    end
  end

  assign bus.out_valid  = vld_pipe[2];
  assign bus.data_out   = data_q;
  assign bus.err_corr   = corr_q;
  assign bus.err_uncorr = uncorr_q;
  assign bus.err_pos    = pos_q;

  // ---------------- saturating error counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (fire_out) begin
      if (corr_q && corr_cnt != '1)     corr_cnt   <= corr_cnt + 1'b1;
      if (uncorr_q && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ham_secded_dec_pipe.sv
module tb_ham_secded_dec_pipe;
  logic clk;
  logic rst_n;
  logic cnt_clr;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic [1:0]  corr_cnt2, uncorr_cnt2;

  int vectors    = 0;
  int miscompares = 0;

  ham_secded_dec_pipe_if #(.DATA_W(4)) b1 ();
  ham_secded_dec_pipe_if #(.DATA_W(4)) b2 ();

  // second decoder sees identical stimulus; only its 2-bit counters are checked
  assign b2.in_valid   = b1.in_valid;
  assign b2.code_in    = b1.code_in;
  assign b2.correct_en = b1.correct_en;
  assign b2.out_ready  = b1.out_ready;

  ham_secded_dec_pipe #(.DATA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  ham_secded_dec_pipe #(.DATA_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // (8,4) encoder: data at positions 3,5,6,7; checks at 1,2,4; bit0 overall parity
  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    c[0] = ^c[7:1];
    return c;
  endfunction

  // single word through an empty pipe, called at a negedge
  task automatic xfer(input string tag, input logic [7:0] code, input logic ce,
                      input logic [3:0] ed, input logic ec, input logic eu,
                      input logic [3:0] ep);
    b1.in_valid = 1'b1; b1.code_in = code; b1.correct_en = ce; b1.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b1.in_valid = 1'b0;
    chk({tag, "_lat1_vld"}, b1.out_valid, 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_vld"},    b1.out_valid, 1);
    chk({tag, "_data"},   b1.data_out, ed);
    chk({tag, "_corr"},   b1.err_corr, ec);
    chk({tag, "_uncorr"}, b1.err_uncorr, eu);
    chk({tag, "_pos"},    b1.err_pos, ep);
    @(posedge clk); @(negedge clk);
    chk({tag, "_drained"}, b1.out_valid, 0);
  endtask

  int sent, got;
  logic held, acc, saw_stall;
  logic [3:0] held_data;

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0;
    b1.in_valid = 1'b0; b1.code_in = '0; b1.correct_en = 1'b1; b1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_in_ready",  b1.in_ready, 1);
    chk("rst_data",      b1.data_out, 0);
    chk("rst_corr",      b1.err_corr, 0);
    chk("rst_uncorr",    b1.err_uncorr, 0);
    chk("rst_pos",       b1.err_pos, 0);
    chk("rst_corr_cnt",  corr_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    xfer("clean_AA", 8'hAA, 1'b1, 4'hB, 1'b0, 1'b0, 4'd0);
    chk("clean_corr_cnt", corr_cnt, 0);
    xfer("single_8A", 8'h8A, 1'b1, 4'hB, 1'b1, 1'b0, 4'd5);
    chk("single_corr_cnt", corr_cnt, 1);
    xfer("par_AB", 8'hAB, 1'b1, 4'hB, 1'b1, 1'b0, 4'd0);
    chk("par_corr_cnt", corr_cnt, 2);
    xfer("double_82", 8'h82, 1'b1, 4'h8, 1'b0, 1'b1, 4'd0);
    chk("double_uncorr_cnt", uncorr_cnt, 1);
    chk("double_corr_cnt", corr_cnt, 2);
    xfer("detect_8A", 8'h8A, 1'b0, 4'h9, 1'b1, 1'b0, 4'd5);
    chk("detect_corr_cnt", corr_cnt, 3);
    xfer("single_p3", 8'hA2, 1'b1, 4'hB, 1'b1, 1'b0, 4'd3);

    // stream of 10 clean words, consumer ready only every third cycle
    sent = 0; got = 0; held = 1'b0; saw_stall = 1'b0; held_data = '0;
    b1.in_valid = 1'b1; b1.code_in = enc(4'd0); b1.correct_en = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      b1.out_ready = (cyc % 3 == 0);
      #1;
      if (held) begin
        chk("hold_vld",  b1.out_valid, 1);
        chk("hold_data", b1.data_out, held_data);
      end
      held = b1.out_valid & ~b1.out_ready;
      held_data = b1.data_out;
      if (!b1.in_ready) saw_stall = 1'b1;
      acc = b1.in_valid & b1.in_ready;
      if (b1.out_valid & b1.out_ready) begin
        chk("stream_data", b1.data_out, got);
        chk("stream_corr", b1.err_corr, 0);
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
      b1.in_valid = (sent < 10);
      b1.code_in  = enc(4'(sent));
    end
    chk("stream_count", got, 10);
    chk("stream_stall_seen", saw_stall, 1);
    b1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream_no_extra", b1.out_valid, 0);

    // reset while words are in flight
    b1.out_ready = 1'b0; b1.in_valid = 1'b1; b1.code_in = enc(4'd1);
    repeat (2) @(negedge clk);
    chk("pre_rst_vld", b1.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", b1.out_valid, 0);
    chk("mid_rst_ready", b1.in_ready, 1);
    chk("mid_rst_corr_cnt", corr_cnt, 0);
    chk("mid_rst_uncorr_cnt", uncorr_cnt, 0);
    b1.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_flushed", b1.out_valid, 0);

    // saturation on the 2-bit counter
    for (int k = 0; k < 5; k++)
      xfer("sat_8A", 8'h8A, 1'b1, 4'hB, 1'b1, 1'b0, 4'd5);
    chk("sat_corr_cnt2", corr_cnt2, 3);
    chk("sat_corr_cnt16", corr_cnt, 5);

    // clear wins over a same-cycle increment
    b1.in_valid = 1'b1; b1.code_in = 8'h8A; b1.correct_en = 1'b1; b1.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b1.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("clr_vld", b1.out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_corr_cnt", corr_cnt, 0);
    chk("clr_corr_cnt2", corr_cnt2, 0);
    chk("clr_consumed", b1.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
